// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter_pkg
//  Purpose  : Shared encodings and types for the memory-port arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package mem_port_arbiter_pkg;

  // Arbiter FSM state encoding
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_BUSY_I = 2'd1;
  localparam logic [1:0] ST_BUSY_D = 2'd2;

  // Transfer size encoding seen by axi_interface
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // Confreg window: virtual upper half and its physical replacement
  localparam logic [15:0] CONFREG_VHI = 16'hbfaf;
  localparam logic [15:0] CONFREG_PHI = 16'h1faf;

  // Owner recorded in last_grant
  localparam logic GRANT_INST = 1'b0;
  localparam logic GRANT_DATA = 1'b1;

  // Request captured at grant and held until the access ends
  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  size;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic        write;
  } mem_req_t;

endpackage : mem_port_arbiter_pkg
`default_nettype wire

// File: rtl/mem_port_arbiter_data_addr_remap.sv
`default_nettype none
// ============================================================================
//  Module   : data_addr_remap
//  Purpose  : Combinational virtual-to-physical translation for data
//             addresses (kseg0/kseg1 strip and confreg window remap).
//  Revision : 1.0 - initial release
// ============================================================================
module data_addr_remap
  import mem_port_arbiter_pkg::*;
#(
  parameter bit REMAP_EN = 1'b1
) (
  input  logic [31:0] vaddr,
  output logic [31:0] paddr
);

  generate
    if (REMAP_EN) begin : g_remap
      // Confreg window takes its own physical page; other kseg addresses drop [31:29]
      always_comb begin
        paddr = vaddr;
        if (vaddr[31:16] == CONFREG_VHI) begin
          paddr = {CONFREG_PHI, vaddr[15:0]};
        end else if (vaddr[31]) begin
          paddr = {3'b000, vaddr[28:0]};
        end
      end
    end else begin : g_bypass
      assign paddr = vaddr;
    end
  endgenerate

endmodule : data_addr_remap
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Purpose  : Shares the single axi_interface port between instruction fetch
//             and data load/store. Latches the winning request at grant,
//             holds it until mem_ready and routes the response back.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter bit RR_EN    = 1'b1,
  parameter bit REMAP_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ready,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_write,
  input  logic [1:0]  d_size,
  input  logic [3:0]  d_sel,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ready,
  output logic [31:0] d_rdata,
  input  logic        flush,
  output logic [31:0] mem_a,
  output logic        mem_access,
  output logic        mem_write,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_sel,
  output logic [31:0] mem_st_data,
  input  logic        mem_ready,
  input  logic [31:0] mem_data,
  output logic        stallreq_if,
  output logic        stallreq_mem
);

  logic [1:0]  r_state;
  logic [1:0]  w_next_state;
  logic        r_last_grant;
  mem_req_t    r_req;
  logic [31:0] w_d_paddr;
  logic        w_d_ok;
  logic        w_grant_i;
  logic        w_grant_d;

  data_addr_remap #(
    .REMAP_EN (REMAP_EN)
  ) u_data_addr_remap (
    .vaddr (d_addr),
    .paddr (w_d_paddr)
  );

  // A flushed data request is never eligible for grant
  assign w_d_ok = d_req & ~flush;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Grant decision in IDLE; completion or flush returns BUSY states to IDLE
  always_comb begin
    w_next_state = r_state;
    w_grant_i    = 1'b0;
    w_grant_d    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_req && w_d_ok) begin
          if (RR_EN) begin
            w_grant_i = (r_last_grant == GRANT_DATA);
            w_grant_d = (r_last_grant == GRANT_INST);
          end else begin
            w_grant_d = 1'b1;
          end
        end else if (i_req) begin
          w_grant_i = 1'b1;
        end else if (w_d_ok) begin
          w_grant_d = 1'b1;
        end
        if (w_grant_i) begin
          w_next_state = ST_BUSY_I;
        end else if (w_grant_d) begin
          w_next_state = ST_BUSY_D;
        end
      end
      ST_BUSY_I, ST_BUSY_D: begin
        if (flush || mem_ready) begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Capture the granted request; it stays frozen until the next grant
  always_ff @(posedge clk) begin
    if (rst) begin
      r_req        <= '0;
      r_last_grant <= GRANT_DATA;
    end else if (w_grant_i) begin
      r_req.addr   <= i_addr;
      r_req.size   <= SIZE_WORD;
      r_req.sel    <= 4'b1111;
      r_req.wdata  <= 32'h0;
      r_req.write  <= 1'b0;
      r_last_grant <= GRANT_INST;
    end else if (w_grant_d) begin
      r_req.addr   <= w_d_paddr;
      r_req.size   <= d_size;
      r_req.sel    <= d_sel;
      r_req.wdata  <= d_wdata;
      r_req.write  <= d_write;
      r_last_grant <= GRANT_DATA;
    end
  end

  // Strobe, response demux and stall requests
  always_comb begin
    mem_access   = (r_state == ST_BUSY_I) || (r_state == ST_BUSY_D);
    i_ready      = (r_state == ST_BUSY_I) && mem_ready && !flush;
    d_ready      = (r_state == ST_BUSY_D) && mem_ready && !flush;
    i_rdata      = i_ready ? mem_data : 32'h0;
    d_rdata      = d_ready ? mem_data : 32'h0;
    stallreq_if  = i_req & ~i_ready;
    stallreq_mem = d_req & ~d_ready;
  end

  assign mem_a       = r_req.addr;
  assign mem_write   = r_req.write;
  assign mem_size    = r_req.size;
  assign mem_sel     = r_req.sel;
  assign mem_st_data = r_req.wdata;

endmodule : mem_port_arbiter
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_port_arbiter
//  Purpose  : Self-checking bench for mem_port_arbiter; a round-robin and a
//             fixed-priority instance share stimulus and a transaction model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic        d_req = 1'b0;
  logic        d_write = 1'b0;
  logic [1:0]  d_size = '0;
  logic [3:0]  d_sel = '0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        flush = 1'b0;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_data = '0;

  // index 0: round-robin instance, index 1: fixed-priority instance
  logic        o_i_ready [2];
  logic [31:0] o_i_rdata [2];
  logic        o_d_ready [2];
  logic [31:0] o_d_rdata [2];
  logic [31:0] o_mem_a [2];
  logic        o_mem_access [2];
  logic        o_mem_write [2];
  logic [1:0]  o_mem_size [2];
  logic [3:0]  o_mem_sel [2];
  logic [31:0] o_mem_st_data [2];
  logic        o_sif [2];
  logic        o_smem [2];

  mem_port_arbiter #(.RR_EN(1'b1), .REMAP_EN(1'b1)) dut_rr (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ready(o_i_ready[0]), .i_rdata(o_i_rdata[0]),
    .d_req(d_req), .d_write(d_write), .d_size(d_size), .d_sel(d_sel),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_ready(o_d_ready[0]), .d_rdata(o_d_rdata[0]),
    .flush(flush),
    .mem_a(o_mem_a[0]), .mem_access(o_mem_access[0]), .mem_write(o_mem_write[0]),
    .mem_size(o_mem_size[0]), .mem_sel(o_mem_sel[0]), .mem_st_data(o_mem_st_data[0]),
    .mem_ready(mem_ready), .mem_data(mem_data),
    .stallreq_if(o_sif[0]), .stallreq_mem(o_smem[0])
  );

  mem_port_arbiter #(.RR_EN(1'b0), .REMAP_EN(1'b1)) dut_fp (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ready(o_i_ready[1]), .i_rdata(o_i_rdata[1]),
    .d_req(d_req), .d_write(d_write), .d_size(d_size), .d_sel(d_sel),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_ready(o_d_ready[1]), .d_rdata(o_d_rdata[1]),
    .flush(flush),
    .mem_a(o_mem_a[1]), .mem_access(o_mem_access[1]), .mem_write(o_mem_write[1]),
    .mem_size(o_mem_size[1]), .mem_sel(o_mem_sel[1]), .mem_st_data(o_mem_st_data[1]),
    .mem_ready(mem_ready), .mem_data(mem_data),
    .stallreq_if(o_sif[1]), .stallreq_mem(o_smem[1])
  );

  // Transaction-level model: who owns the port (0 none, 1 fetch, 2 data),
  // who was served last, and the request captured for the current owner.
  int          m_owner [2] = '{0, 0};
  bit          m_last_data [2] = '{1'b1, 1'b1};
  logic [31:0] m_addr [2] = '{32'h0, 32'h0};
  logic [31:0] m_wdata [2] = '{32'h0, 32'h0};
  logic [1:0]  m_size [2] = '{2'd0, 2'd0};
  logic [3:0]  m_sel [2] = '{4'd0, 4'd0};
  bit          m_write [2] = '{1'b0, 1'b0};

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] phys_of(input logic [31:0] a);
    if ((a >> 16) == 32'h0000_bfaf) return 32'h1faf_0000 + (a % 32'h1_0000);
    if (a >= 32'h8000_0000) return a % 32'h2000_0000;
    return a;
  endfunction

  task automatic check_outputs();
    for (int k = 0; k < 2; k++) begin
      string p;
      bit    exp_ir;
      bit    exp_dr;
      p      = (k == 0) ? "rr" : "fp";
      exp_ir = (m_owner[k] == 1) && mem_ready && !flush;
      exp_dr = (m_owner[k] == 2) && mem_ready && !flush;
      check_val({p, ".mem_access"},  32'(o_mem_access[k]), 32'(m_owner[k] != 0));
      check_val({p, ".mem_a"},       o_mem_a[k], m_addr[k]);
      check_val({p, ".mem_write"},   32'(o_mem_write[k]), 32'(m_write[k]));
      check_val({p, ".mem_size"},    32'(o_mem_size[k]), 32'(m_size[k]));
      check_val({p, ".mem_sel"},     32'(o_mem_sel[k]), 32'(m_sel[k]));
      check_val({p, ".mem_st_data"}, o_mem_st_data[k], m_wdata[k]);
      check_val({p, ".i_ready"},     32'(o_i_ready[k]), 32'(exp_ir));
      check_val({p, ".i_rdata"},     o_i_rdata[k], exp_ir ? mem_data : 32'h0);
      check_val({p, ".d_ready"},     32'(o_d_ready[k]), 32'(exp_dr));
      check_val({p, ".d_rdata"},     o_d_rdata[k], exp_dr ? mem_data : 32'h0);
      check_val({p, ".stallreq_if"}, 32'(o_sif[k]), 32'(i_req && !exp_ir));
      check_val({p, ".stallreq_mem"},32'(o_smem[k]), 32'(d_req && !exp_dr));
    end
  endtask

  // Advance the model across one rising edge using the inputs present at it
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_owner[k] = 0; m_last_data[k] = 1'b1;
        m_addr[k] = '0; m_wdata[k] = '0; m_size[k] = '0; m_sel[k] = '0; m_write[k] = 1'b0;
      end else if (m_owner[k] != 0) begin
        if (flush || mem_ready) m_owner[k] = 0;
      end else begin
        bit d_ok;
        int g;
        d_ok = d_req && !flush;
        g = 0;
        if (i_req && d_ok) g = (k == 0) ? (m_last_data[k] ? 1 : 2) : 2;
        else if (i_req)    g = 1;
        else if (d_ok)     g = 2;
        if (g == 1) begin
          m_addr[k] = i_addr; m_size[k] = 2'd2; m_sel[k] = 4'hf;
          m_wdata[k] = 32'h0; m_write[k] = 1'b0; m_last_data[k] = 1'b0;
        end else if (g == 2) begin
          m_addr[k] = phys_of(d_addr); m_size[k] = d_size; m_sel[k] = d_sel;
          m_wdata[k] = d_wdata; m_write[k] = d_write; m_last_data[k] = 1'b1;
        end
        m_owner[k] = g;
      end
    end
  endtask

  // Caller sets inputs just after a rising edge; this checks mid-cycle and
  // returns just after the next rising edge with the model updated.
  task automatic cycle();
    #4;
    check_outputs();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic go_idle();
    i_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0; flush = 1'b0;
    cycle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1);
  end

  initial begin
    bit seen;

    // Reset with a fetch request pending: stall follows its equation
    rst = 1'b1; i_req = 1'b1;
    @(posedge clk); model_step(); #1;
    #2;
    check_val("rst.mem_access", 32'(o_mem_access[0]), 32'd0);
    check_val("rst.mem_a", o_mem_a[0], 32'h0);
    check_val("rst.stallreq_if", 32'(o_sif[0]), 32'd1);
    cycle();

    // Fetch from boot ROM, response three cycles after the request
    rst = 1'b0; i_req = 1'b1; i_addr = 32'hbfc0_0000;
    cycle();
    #2;
    check_val("if.mem_a", o_mem_a[0], 32'hbfc0_0000);
    check_val("if.mem_size", 32'(o_mem_size[0]), 32'd2);
    check_val("if.mem_sel", 32'(o_mem_sel[0]), 32'hf);
    check_val("if.mem_write", 32'(o_mem_write[0]), 32'd0);
    check_val("if.stall", 32'(o_sif[0]), 32'd1);
    cycle();
    cycle();
    mem_ready = 1'b1; mem_data = 32'h3c1d_0000;
    #2;
    check_val("if.i_ready", 32'(o_i_ready[0]), 32'd1);
    check_val("if.i_rdata", o_i_rdata[0], 32'h3c1d_0000);
    check_val("if.stall_clear", 32'(o_sif[0]), 32'd0);
    cycle();
    go_idle();

    // Store to the confreg window
    d_req = 1'b1; d_write = 1'b1; d_addr = 32'hbfaf_8000; d_sel = 4'b0011;
    d_size = 2'd1; d_wdata = 32'h0000_1234;
    cycle();
    #2;
    check_val("st.mem_a", o_mem_a[0], 32'h1faf_8000);
    check_val("st.mem_write", 32'(o_mem_write[0]), 32'd1);
    check_val("st.mem_st_data", o_mem_st_data[0], 32'h0000_1234);
    mem_ready = 1'b1;
    #1;
    check_val("st.d_ready", 32'(o_d_ready[0]), 32'd1);
    check_val("st.i_ready", 32'(o_i_ready[0]), 32'd0);
    cycle();
    go_idle();

    // kseg0 load strips the segment bits
    d_req = 1'b1; d_write = 1'b0; d_addr = 32'h8000_1004; d_size = 2'd2; d_sel = 4'hf;
    cycle();
    #2;
    check_val("ld.mem_a", o_mem_a[0], 32'h0000_1004);
    mem_ready = 1'b1; mem_data = 32'hcafe_f00d;
    #1;
    check_val("ld.d_rdata", o_d_rdata[0], 32'hcafe_f00d);
    cycle();
    go_idle();

    // Continuous contention from reset: RR alternates starting with fetch
    rst = 1'b1;
    cycle();
    rst = 1'b0; i_req = 1'b1; d_req = 1'b1; d_addr = 32'h0000_2000; i_addr = 32'h0000_0100;
    for (int n = 0; n < 4; n++) begin
      seen = 1'b0;
      for (int w = 0; w < 8 && !seen; w++) begin
        if (o_mem_access[0]) seen = 1'b1;
        else cycle();
      end
      if (!seen) check_val("order.timeout", 32'd0, 32'd1);
      mem_ready = 1'b1;
      #1;
      check_val("order.rr_d", 32'(o_d_ready[0]), 32'(n % 2));
      check_val("order.rr_i", 32'(o_i_ready[0]), 32'((n + 1) % 2));
      check_val("order.fp_d", 32'(o_d_ready[1]), 32'd1);
      cycle();
      mem_ready = 1'b0;
    end
    go_idle();

    // Flush two cycles into a data access, coincident with mem_ready
    d_req = 1'b1; d_write = 1'b0; d_addr = 32'h0000_3000;
    cycle();
    cycle();
    flush = 1'b1; mem_ready = 1'b1; d_req = 1'b0;
    #2;
    check_val("fl.d_ready", 32'(o_d_ready[0]), 32'd0);
    check_val("fl.d_rdata", o_d_rdata[0], 32'h0);
    cycle();
    flush = 1'b0; mem_ready = 1'b0;
    #1;
    check_val("fl.idle", 32'(o_mem_access[0]), 32'd0);
    i_req = 1'b1; i_addr = 32'h0000_4444;
    cycle();
    #1;
    check_val("fl.regrant", o_mem_a[0], 32'h0000_4444);
    mem_ready = 1'b1;
    #1;
    check_val("fl.i_ready", 32'(o_i_ready[0]), 32'd1);
    cycle();
    go_idle();

    // Request withdrawn mid-access: latched store is unaffected
    d_req = 1'b1; d_write = 1'b1; d_addr = 32'h0000_0010; d_wdata = 32'h0000_aa55;
    cycle();
    d_req = 1'b0; d_write = 1'b0; d_addr = 32'hffff_0000; d_wdata = 32'h0;
    cycle();
    #1;
    check_val("wd.mem_a", o_mem_a[0], 32'h0000_0010);
    check_val("wd.mem_write", 32'(o_mem_write[0]), 32'd1);
    check_val("wd.mem_st_data", o_mem_st_data[0], 32'h0000_aa55);
    mem_ready = 1'b1;
    #1;
    check_val("wd.d_ready", 32'(o_d_ready[0]), 32'd1);
    cycle();
    go_idle();

    // Random traffic against the model
    for (int c = 0; c < 600; c++) begin
      rst       = ($urandom_range(0, 149) == 0);
      i_req     = ($urandom_range(0, 9) < 6);
      d_req     = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 19) == 0);
      mem_ready = ($urandom_range(0, 9) < 4);
      mem_data  = $urandom;
      i_addr    = $urandom;
      d_write   = $urandom_range(0, 1);
      d_size    = 2'($urandom_range(0, 2));
      d_sel     = 4'($urandom);
      d_wdata   = $urandom;
      case ($urandom_range(0, 3))
        0: d_addr = 32'hbfaf_0000 | ($urandom % 32'h1_0000);
        1: d_addr = 32'h8000_0000 | ($urandom % 32'h4000_0000);
        2: d_addr = $urandom % 32'h8000_0000;
        default: d_addr = $urandom;
      endcase
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_mem_port_arbiter
`default_nettype wire
